// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus driver: state encoding,
// instruction-word field positions and default 50 MHz timing constants.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SETUP   = 3'd2,
    ST_PULSE   = 3'd3,
    ST_HOLD    = 3'd4,
    ST_WAIT    = 3'd5
  } lcd_state_e;

  localparam int CMD_W    = 11;
  localparam int RS_BIT   = 10;
  localparam int RW_BIT   = 9;
  localparam int LONG_BIT = 8;
  localparam int DATA_MSB = 7;

  localparam int unsigned DEF_SETUP_CYC      = 4;
  localparam int unsigned DEF_E_HIGH_CYC     = 25;
  localparam int unsigned DEF_HOLD_CYC       = 2;
  localparam int unsigned DEF_SHORT_WAIT_CYC = 2000;
  localparam int unsigned DEF_LONG_WAIT_CYC  = 82000;
  localparam int unsigned DEF_POWERUP_CYC    = 750000;
  localparam int          DEF_CNT_W          = 20;

  // Clear (0x01) and home (0x02/0x03) are the only instructions with RS=0
  // and data[7:2]==0; they need the long execution wait, as does any
  // command that explicitly requests it.
  function automatic logic is_long_cmd(input logic [CMD_W-1:0] c);
    return c[LONG_BIT] || (!c[RS_BIT] && (c[DATA_MSB:2] == 6'b0));
  endfunction

endpackage

// File: rtl/lcd_bus_driver_counter.sv
// Loadable down-counter shared by every timed phase of the LCD bus driver.
// It saturates at zero; a load takes priority over counting.
module lcd_delay_counter #(
  parameter int              CNT_W     = 20,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780-style LCD bus driver: takes one instruction word at a time and
// generates RS/RW/data setup, the E strobe, hold and execution wait.
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC      = DEF_SETUP_CYC,
  parameter int unsigned E_HIGH_CYC     = DEF_E_HIGH_CYC,
  parameter int unsigned HOLD_CYC       = DEF_HOLD_CYC,
  parameter int unsigned SHORT_WAIT_CYC = DEF_SHORT_WAIT_CYC,
  parameter int unsigned LONG_WAIT_CYC  = DEF_LONG_WAIT_CYC,
  parameter int unsigned POWERUP_CYC    = DEF_POWERUP_CYC,
  parameter int          CNT_W          = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [10:0] cmd,
  output logic        cmd_ready,
  output logic        busy,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e,
  output logic [7:0]  lcd_data
);

  // Reload values are parameter-1 so each state lasts exactly its parameter.
  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_HIGH_LD  = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SHORT_LD   = CNT_W'(SHORT_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD    = CNT_W'(LONG_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] POWERUP_LD = CNT_W'(POWERUP_CYC - 1);

  lcd_state_e       state_q, state_d;
  logic             rs_q, rs_d;
  logic             rw_q, rw_d;
  logic [7:0]       data_q, data_d;
  logic             long_q, long_d;
  logic             e_q, e_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;
  logic             accept;

  lcd_delay_counter #(
    .CNT_W     (CNT_W),
    .RESET_VAL (POWERUP_LD)
  ) u_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  assign accept = cmd_valid && ready_q;

  always_comb begin
    state_d      = state_q;
    rs_d         = rs_q;
    rw_d         = rw_q;
    data_d       = data_q;
    long_d       = long_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;

    unique case (state_q)
      ST_POWERUP: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          rs_d         = cmd[RS_BIT];
          rw_d         = cmd[RW_BIT];
          data_d       = cmd[DATA_MSB:0];
          long_d       = is_long_cmd(cmd);
          cnt_load     = 1'b1;
          cnt_load_val = SETUP_LD;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = E_HIGH_LD;
          state_d      = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LD;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = long_q ? LONG_LD : SHORT_LD;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_POWERUP;
      end
    endcase
  end

  // Status and strobe flops are decoded from the next state so that they
  // line up exactly with the state register and never glitch.
  always_comb begin
    e_d     = (state_d == ST_PULSE);
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_POWERUP;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
      e_q     <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      data_q  <= data_d;
      long_q  <= long_d;
      e_q     <= e_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = rw_q;
  assign lcd_e     = e_q;
  assign lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Self-checking bench for lcd_bus_driver with short simulation timings and a
// transaction-level timeline model of the expected pin behaviour.
module tb_lcd_bus_driver;

  localparam int S  = 2;
  localparam int EH = 3;
  localparam int H  = 1;
  localparam int SW = 5;
  localparam int LW = 12;
  localparam int P  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [10:0] cmd = 11'h000;
  logic        cmd_ready, busy, lcd_rs, lcd_rw, lcd_e;
  logic [7:0]  lcd_data;

  lcd_bus_driver #(
    .SETUP_CYC(S), .E_HIGH_CYC(EH), .HOLD_CYC(H), .SHORT_WAIT_CYC(SW),
    .LONG_WAIT_CYC(LW), .POWERUP_CYC(P), .CNT_W(20)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(cmd_ready), .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Timeline model: edge index of the last reset / accept, and duration of
  // the accepted command from accept edge to ready.
  int   cyc = 0;
  int   pu_edge = 0;
  int   acc_edge = -1;
  int   acc_dur = 0;
  int   n_acc = 0;
  int   n_pulse = 0;
  logic exp_rs = 1'b0, exp_rw = 1'b0, exp_e = 1'b0, exp_busy = 1'b1;
  logic exp_ready = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic prev_e = 1'b0;
  logic [7:0] q_acc[$];
  logic [7:0] q_pulse[$];
  int   acc_edges[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic long_rule(input logic [10:0] c);
    return c[8] || (c[10] == 1'b0 && c[7:2] == 6'd0);
  endfunction

  task automatic step();
    logic        rst_now, acc_now;
    logic [10:0] c;
    int          d;
    rst_now = reset;
    c       = cmd;
    acc_now = !reset && cmd_valid && exp_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_now) begin
      pu_edge  = cyc;
      acc_edge = -1;
      exp_rs   = 1'b0;
      exp_rw   = 1'b0;
      exp_data = 8'h00;
    end else if (acc_now) begin
      acc_edge = cyc;
      acc_dur  = S + EH + H + (long_rule(c) ? LW : SW);
      exp_rs   = c[10];
      exp_rw   = c[9];
      exp_data = c[7:0];
      n_acc++;
      q_acc.push_back(c[7:0]);
      acc_edges.push_back(cyc);
    end
    if (acc_edge < 0) begin
      exp_e    = 1'b0;
      exp_busy = (cyc - pu_edge) < P;
    end else begin
      d        = cyc - acc_edge;
      exp_e    = (d >= S) && (d < S + EH);
      exp_busy = d < acc_dur;
    end
    exp_ready = !exp_busy;
    check("busy", 32'(busy), 32'(exp_busy));
    check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    check("lcd_e", 32'(lcd_e), 32'(exp_e));
    check("lcd_rs", 32'(lcd_rs), 32'(exp_rs));
    check("lcd_rw", 32'(lcd_rw), 32'(exp_rw));
    check("lcd_data", 32'(lcd_data), 32'(exp_data));
    if (lcd_e && !prev_e) begin
      n_pulse++;
      q_pulse.push_back(lcd_data);
    end
    prev_e = lcd_e;
  endtask

  task automatic issue(input logic [10:0] c);
    int start;
    int k;
    start     = n_acc;
    cmd       = c;
    cmd_valid = 1'b1;
    k = 0;
    while (n_acc == start && k < 200) begin
      step();
      k++;
    end
    if (n_acc == start) check("issue_timeout", 32'(k), 32'(0));
    cmd_valid = 1'b0;
  endtask

  // Issues a command and measures, from the DUT pins, E-rise and ready latency.
  task automatic measure_cmd(input logic [10:0] c, input int exp_rise, input int exp_rdy);
    int k;
    int rise;
    issue(c);
    k    = 0;
    rise = -1;
    while (!cmd_ready && k < 200) begin
      step();
      k++;
      if (lcd_e && rise < 0) rise = k;
    end
    check("ready_latency", 32'(k), 32'(exp_rdy));
    check("e_rise_latency", 32'(rise), 32'(exp_rise));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!exp_ready && k < 200) begin
      step();
      k++;
    end
    check("wait_idle", 32'(cmd_ready), 32'(1));
  endtask

  initial begin
    int k;
    int p0;
    int a0;
    logic [7:0] dbyte;
    logic [10:0] c;

    // Reset and power-up wait
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    k = 0;
    while (!cmd_ready && k < 50) begin
      step();
      k++;
    end
    check("powerup_len", 32'(k), 32'(P));

    // Short data write, clear, and forced long wait
    measure_cmd(11'h441, S, S + EH + H + SW);
    check("rs_after_441", 32'(lcd_rs), 32'(1));
    check("data_after_441", 32'(lcd_data), 32'h41);
    measure_cmd(11'h001, S, S + EH + H + LW);
    measure_cmd(11'h138, S, S + EH + H + LW);
    measure_cmd(11'h003, S, S + EH + H + LW);
    measure_cmd(11'h00C, S, S + EH + H + SW);

    // cmd_valid held through busy with changing cmd: only the ready-edge value counts
    p0 = n_pulse;
    a0 = n_acc;
    issue(11'h450);
    cmd_valid = 1'b1;
    k = 0;
    while (n_acc == a0 + 1 && k < 200) begin
      cmd = {3'b100, 8'($urandom_range(8'h20, 8'h7E))};
      c   = cmd;
      step();
      k++;
    end
    cmd_valid = 1'b0;
    check("held_accept_data", 32'(lcd_data), 32'(c[7:0]));
    wait_idle();
    check("held_pulses", 32'(n_pulse - p0), 32'(2));

    // Reset in the middle of the E pulse
    issue(11'h44A);
    k = 0;
    while (!exp_e && k < 50) begin
      step();
      k++;
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_e", 32'(lcd_e), 32'(0));
    check("reset_data", 32'(lcd_data), 32'(0));
    check("reset_ready", 32'(cmd_ready), 32'(0));
    k = 0;
    while (!cmd_ready && k < 50) begin
      step();
      k++;
    end
    check("repowerup_len", 32'(k), 32'(P));

    // Stream of 40 back-to-back short data writes
    p0 = n_pulse;
    a0 = acc_edges.size();
    for (int i = 0; i < 40; i++) begin
      dbyte = 8'($urandom);
      issue({3'b100, dbyte});
    end
    wait_idle();
    check("stream_pulses", 32'(n_pulse - p0), 32'(40));
    for (int i = a0 + 1; i < acc_edges.size(); i++) begin
      check("stream_spacing", 32'(acc_edges[i] - acc_edges[i-1]), 32'(S + EH + H + SW + 1));
    end

    // Random mix of instructions and idle gaps
    for (int i = 0; i < 30; i++) begin
      c = 11'($urandom);
      if ($urandom_range(0, 3) == 0) c[10:2] = 9'h000;
      issue(c);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
    end
    wait_idle();
    for (int i = 0; i < 4; i++) step();

    check("pulse_count_total", 32'(q_pulse.size()), 32'(q_acc.size()));
    for (int i = 0; i < q_acc.size() && i < q_pulse.size(); i++) begin
      check("pulse_data_order", 32'(q_pulse[i]), 32'(q_acc[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
